// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file for the ID stage, with two
// write-back ports (EX = wb0, MEM = wb1), a per-register busy scoreboard
// and a registered count of outstanding producers.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rd_addr_1/2             source register indices
//   rd_data_1/2, rd_busy_1/2  combinational operand values and busy flags
//   issue_en, issue_addr    mark a destination register busy at issue
//   wb0_en/addr/data        EX write-back port
//   wb1_en/addr/data        MEM write-back port (wins on address collision)
//   flush                   clear every busy bit (branch redirect)
//   busy_count              registered population count of the busy vector
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data to the read ports and hide the busy flag of the register being
// retired. Without it, reads see only stored state.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [ADDR_W:0]   count_next;
  logic              wb0_ok;
  logic              wb1_ok;

  // A write-back is effective unless it targets the hardwired zero register.
  always_comb begin
    wb0_ok = wb0_en && !((ZERO_REG != 0) && (wb0_addr == '0));
    wb1_ok = wb1_en && !((ZERO_REG != 0) && (wb1_addr == '0));
  end

  // Register array. wb1 is written second so it wins when both ports hit
  // the same register: it carries the long-latency load result the
  // scoreboard is waiting for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wb0_ok) regs[wb0_addr] <= wb0_data;
      if (wb1_ok) regs[wb1_addr] <= wb1_data;
    end
  end

  // Next busy vector: flush beats issue, issue beats write-back retirement,
  // so an issue that lands on a register being retired leaves it busy for
  // the new producer.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (flush)
        busy_next[r] = 1'b0;
      else if (issue_en && (issue_addr == ADDR_W'(r)))
        busy_next[r] = 1'b1;
      else if ((wb0_en && (wb0_addr == ADDR_W'(r))) ||
               (wb1_en && (wb1_addr == ADDR_W'(r))))
        busy_next[r] = 1'b0;
    end
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  // Population count of the next busy vector, so the registered count
  // matches the busy bits right after each edge.
  always_comb begin
    count_next = '0;
    for (int r = 0; r < NREGS; r++)
      count_next = count_next + (ADDR_W + 1)'(busy_next[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // Two identical read ports.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = (p == 0) ? rd_addr_1 : rd_addr_2;

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // Forwarded write-back: wb1 checked last so it overrides wb0, and the
      // register being retired no longer looks busy. Nothing is forwarded
      // while reset is held.
      if (wb0_ok && (wb0_addr == addr)) begin
        data = wb0_data;
        bsy  = 1'b0;
      end
      if (wb1_ok && (wb1_addr == addr)) begin
        data = wb1_data;
        bsy  = 1'b0;
      end
      if (!rst_n) begin
        data = '0;
        bsy  = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end
  end

  assign rd_data_1 = g_rd[0].data;
  assign rd_busy_1 = g_rd[0].bsy;
  assign rd_data_2 = g_rd[1].data;
  assign rd_busy_2 = g_rd[1].bsy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb with default
// parameters (DATA_W=32, ADDR_W=5, ZERO_REG=1). Inputs change 1 time unit
// after a rising edge; outputs are sampled mid-cycle.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;
  logic        rd_busy_1;
  logic        rd_busy_2;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        wb0_en;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_en;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        flush;
  logic [5:0]  busy_count;

  int compared   = 0;
  int mismatched = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_1  (rd_addr_1),
    .rd_addr_2  (rd_addr_2),
    .rd_data_1  (rd_data_1),
    .rd_data_2  (rd_data_2),
    .rd_busy_1  (rd_busy_1),
    .rd_busy_2  (rd_busy_2),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb0_en     (wb0_en),
    .wb0_addr   (wb0_addr),
    .wb0_data   (wb0_data),
    .wb1_en     (wb1_en),
    .wb1_addr   (wb1_addr),
    .wb1_data   (wb1_data),
    .flush      (flush),
    .busy_count (busy_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return every request input to idle.
  task automatic idle_inputs();
    issue_en = 1'b0; issue_addr = '0;
    wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
    flush = 1'b0;
  endtask

  // Reset values while held, then an asynchronous mid-cycle reset that
  // clears a preloaded register and a busy bit with no clock edge.
  task automatic test_reset();
    #2;
    compared++;
    if (busy_count !== 6'd0 || rd_data_1 !== 32'd0 || rd_busy_1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_hold: count=%0d data=%h busy=%b, required 0/0/0",
               busy_count, rd_data_1, rd_busy_1);
    end
    rst_n = 1'b1;
    step();
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_addr = 5'd6;
    step();
    idle_inputs();
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd6;
    #1;
    compared++;
    if (rd_data_1 !== 32'hDEADBEEF || rd_busy_2 !== 1'b1 || busy_count !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL preload: data=%h busy6=%b count=%0d, required deadbeef/1/1",
               rd_data_1, rd_busy_2, busy_count);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if (rd_data_1 !== 32'd0 || rd_busy_2 !== 1'b0 || busy_count !== 6'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: data=%h busy6=%b count=%0d, required 0/0/0",
               rd_data_1, rd_busy_2, busy_count);
    end
    #1 rst_n = 1'b1;
  endtask

  // Issue r7, retire it via wb0 two edges later.
  task automatic test_issue_wb();
    step();
    rd_addr_1 = 5'd7;
    issue_en = 1'b1; issue_addr = 5'd7;
    step();
    idle_inputs();
    compared++;
    if (rd_busy_1 !== 1'b1 || busy_count !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL issue_r7_c1: busy=%b count=%0d, required 1/1", rd_busy_1, busy_count);
    end
    step();
    compared++;
    if (rd_busy_1 !== 1'b1 || busy_count !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL issue_r7_c2: busy=%b count=%0d, required 1/1", rd_busy_1, busy_count);
    end
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1234;
    step();
    idle_inputs();
    compared++;
    if (rd_busy_1 !== 1'b0 || rd_data_1 !== 32'h1234 || busy_count !== 6'd0) begin
      mismatched++;
      $display("[TB] FAIL wb0_r7: busy=%b data=%h count=%0d, required 0/00001234/0",
               rd_busy_1, rd_data_1, busy_count);
    end
  endtask

  // Both ports write r3 on the same edge: wb1 must win.
  task automatic test_dual_wb();
    wb0_en = 1'b1; wb0_addr = 5'd3; wb0_data = 32'hAAAA;
    wb1_en = 1'b1; wb1_addr = 5'd3; wb1_data = 32'h5555;
    step();
    idle_inputs();
    rd_addr_2 = 5'd3;
    #1;
    compared++;
    if (rd_data_2 !== 32'h5555) begin
      mismatched++;
      $display("[TB] FAIL dual_wb_r3: got %h, required 00005555", rd_data_2);
    end
  endtask

  // Issue and wb1 on r9 together, then flush that collides with an issue.
  task automatic test_issue_and_flush();
    rd_addr_1 = 5'd10; rd_addr_2 = 5'd9;
    issue_en = 1'b1; issue_addr = 5'd9;
    wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h77;
    step();
    idle_inputs();
    compared++;
    if (rd_busy_2 !== 1'b1 || rd_data_2 !== 32'h77 || busy_count !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL issue_wb_r9: busy=%b data=%h count=%0d, required 1/00000077/1",
               rd_busy_2, rd_data_2, busy_count);
    end
    flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd10;
    step();
    idle_inputs();
    compared++;
    if (busy_count !== 6'd0 || rd_busy_1 !== 1'b0 || rd_busy_2 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_issue: count=%0d busy10=%b busy9=%b, required 0/0/0",
               busy_count, rd_busy_1, rd_busy_2);
    end
  endtask

  // Register 0 ignores issue and writes; the count is left untouched.
  task automatic test_zero_reg();
    issue_en = 1'b1; issue_addr = 5'd12;
    step();
    issue_en = 1'b1; issue_addr = 5'd0;
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFF;
    rd_addr_1 = 5'd0;
    #1;
    compared++;
    if (rd_data_1 !== 32'd0 || rd_busy_1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL r0_same_cycle: data=%h busy=%b, required 0/0", rd_data_1, rd_busy_1);
    end
    step();
    idle_inputs();
    compared++;
    if (rd_data_1 !== 32'd0 || rd_busy_1 !== 1'b0 || busy_count !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL r0_after: data=%h busy=%b count=%0d, required 0/0/1",
               rd_data_1, rd_busy_1, busy_count);
    end
    flush = 1'b1;
    step();
    idle_inputs();
  endtask

  // Read of r4 in the same cycle a wb1 retires it.
  task automatic test_bypass();
    issue_en = 1'b1; issue_addr = 5'd4;
    wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h1111;
    step();
    idle_inputs();
    rd_addr_1 = 5'd4;
    wb1_en = 1'b1; wb1_addr = 5'd4; wb1_data = 32'hCAFE;
    #1;
    compared++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data_1 !== 32'hCAFE || rd_busy_1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bypass_same_cycle: data=%h busy=%b, required 0000cafe/0",
               rd_data_1, rd_busy_1);
    end
`else
    if (rd_data_1 !== 32'h1111 || rd_busy_1 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL no_bypass_same_cycle: data=%h busy=%b, required 00001111/1",
               rd_data_1, rd_busy_1);
    end
`endif
    step();
    idle_inputs();
    compared++;
    if (rd_data_1 !== 32'hCAFE || rd_busy_1 !== 1'b0 || busy_count !== 6'd0) begin
      mismatched++;
      $display("[TB] FAIL wb1_r4_after: data=%h busy=%b count=%0d, required 0000cafe/0/0",
               rd_data_1, rd_busy_1, busy_count);
    end
  endtask

  // Consecutive issues and write-backs; both ports retire on one edge.
  task automatic test_back_to_back();
    issue_en = 1'b1; issue_addr = 5'd20;
    step();
    issue_addr = 5'd21;
    step();
    issue_addr = 5'd22;
    step();
    idle_inputs();
    compared++;
    if (busy_count !== 6'd3) begin
      mismatched++;
      $display("[TB] FAIL b2b_count3: got %0d, required 3", busy_count);
    end
    wb0_en = 1'b1; wb0_addr = 5'd20; wb0_data = 32'h100;
    wb1_en = 1'b1; wb1_addr = 5'd21; wb1_data = 32'h200;
    step();
    wb1_en = 1'b0;
    wb0_addr = 5'd20; wb0_data = 32'h101;
    step();
    idle_inputs();
    rd_addr_1 = 5'd20; rd_addr_2 = 5'd21;
    #1;
    compared++;
    if (busy_count !== 6'd1 || rd_data_1 !== 32'h101 || rd_data_2 !== 32'h200 ||
        rd_busy_1 !== 1'b0 || rd_busy_2 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_retire: count=%0d d20=%h d21=%h b20=%b b21=%b, required 1/101/200/0/0",
               busy_count, rd_data_1, rd_data_2, rd_busy_1, rd_busy_2);
    end
    rd_addr_1 = 5'd22;
    #1;
    compared++;
    if (rd_busy_1 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_r22_busy: got %b, required 1", rd_busy_1);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst_n = 1'b0;
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd0;
    idle_inputs();
    test_reset();
    test_issue_wb();
    test_dual_wb();
    test_issue_and_flush();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
